// File: rtl/webshooter_status_tx_pkg.sv
// Shared definitions for the WebShooter status/telemetry transmitter.
// Frame byte indices, FSM encoding, snapshot layout and last-index
// selection. Macro WEBSHOOTER_TX_CHECKSUM_EN adds the XOR checksum byte.
package webshooter_status_tx_pkg;

   localparam logic [7:0] HEADER_BYTE = 8'hA5;

   localparam logic [2:0] IDX_HEADER   = 3'd0;
   localparam logic [2:0] IDX_CMD      = 3'd1;
   localparam logic [2:0] IDX_X        = 3'd2;
   localparam logic [2:0] IDX_Y        = 3'd3;
   localparam logic [2:0] IDX_Z        = 3'd4;
   localparam logic [2:0] IDX_TIME     = 3'd5;
   localparam logic [2:0] IDX_STATUS   = 3'd6;
   localparam logic [2:0] IDX_CHECKSUM = 3'd7;

`ifdef WEBSHOOTER_TX_CHECKSUM_EN
   localparam logic [2:0] LAST_IDX = IDX_CHECKSUM;
`else
   localparam logic [2:0] LAST_IDX = IDX_STATUS;
`endif

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StDone = 2'd2
   } txState_t;

   typedef struct packed {
      logic [3:0] targetSelect;
      logic [2:0] functionSelect;
      logic [7:0] xCoord;
      logic [7:0] yCoord;
      logic [7:0] zCoord;
      logic [7:0] timeCoord;
      logic       energyEmpty;
      logic [5:0] tracerCount;
   } snapshot_t;

   localparam int SNAP_W = $bits(snapshot_t);

endpackage

// File: rtl/webshooter_frame_mux.sv
// Combinational frame byte selector: picks the snapshot byte for byteIndex.
// Ports: snapBits (packed snapshot), byteIndex, checksum, frameByte.
module webshooter_frame_mux
   import webshooter_status_tx_pkg::*;
(
   input  logic [SNAP_W-1:0] snapBits,
   input  logic [2:0]        byteIndex,
   input  logic [7:0]        checksum,
   output logic [7:0]        frameByte
);

   snapshot_t snap;

   assign snap = snapshot_t'(snapBits);

   always_comb begin
      frameByte = 8'h00;
      unique case (byteIndex)
         IDX_HEADER:   frameByte = HEADER_BYTE;
         IDX_CMD:      frameByte = {snap.targetSelect,
                                    snap.functionSelect, 1'b0};
         IDX_X:        frameByte = snap.xCoord;
         IDX_Y:        frameByte = snap.yCoord;
         IDX_Z:        frameByte = snap.zCoord;
         IDX_TIME:     frameByte = snap.timeCoord;
         IDX_STATUS:   frameByte = {snap.energyEmpty, 1'b0,
                                    snap.tracerCount};
         IDX_CHECKSUM: frameByte = checksum;
      endcase
   end

endmodule

// File: rtl/webshooter_status_tx.sv
// Status frame transmitter: snapshots command/status fields on request
// and streams a fixed byte frame over TxValid/TxReady.
// Ports: clk, reset (async high), ReportReq, command/status inputs,
// TxData/TxValid/TxReady link, Busy, FrameDone.
// Optional macro: WEBSHOOTER_TX_CHECKSUM_EN (appends XOR checksum byte).
module webshooter_status_tx
   import webshooter_status_tx_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       ReportReq,
   input  logic [3:0] TelemetryTargetSelect,
   input  logic [2:0] WebFunctionSelect,
   input  logic [7:0] XCoordinate,
   input  logic [7:0] YCoordinate,
   input  logic [7:0] ZCoordinate,
   input  logic [7:0] TimeCoordinate,
   input  logic [5:0] tracerCount,
   input  logic       energyEmpty,
   output logic [7:0] TxData,
   output logic       TxValid,
   input  logic       TxReady,
   output logic       Busy,
   output logic       FrameDone
);

   txState_t  state;
   txState_t  nextState;
   logic [2:0] byteIdx;
   logic       pending;
   snapshot_t  snap;
   snapshot_t  freshSnap;
   logic [7:0] muxByte;
   logic [7:0] csumByte;
   logic       handshake;
   logic       lastByte;
   logic       takeSnap;

   assign freshSnap.targetSelect   = TelemetryTargetSelect;
   assign freshSnap.functionSelect = WebFunctionSelect;
   assign freshSnap.xCoord         = XCoordinate;
   assign freshSnap.yCoord         = YCoordinate;
   assign freshSnap.zCoord         = ZCoordinate;
   assign freshSnap.timeCoord      = TimeCoordinate;
   assign freshSnap.energyEmpty    = energyEmpty;
   assign freshSnap.tracerCount    = tracerCount;

   assign handshake = (state == StSend) && TxReady;
   assign lastByte  = (byteIdx == LAST_IDX);

   // A request seen in DONE is served right away along with any
   // request merged into the pending flag during the frame.
   assign takeSnap = ((state == StIdle) && ReportReq) ||
                     ((state == StDone) && (pending || ReportReq));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= StIdle;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         StIdle: if (ReportReq) nextState = StSend;
         StSend: if (handshake && lastByte) nextState = StDone;
         StDone: nextState = (pending || ReportReq) ? StSend : StIdle;
         default: nextState = StIdle;
      endcase
   end

   always_comb begin
      TxValid   = 1'b0;
      TxData    = 8'h00;
      Busy      = 1'b0;
      FrameDone = 1'b0;
      unique case (state)
         StSend: begin
            TxValid = 1'b1;
            TxData  = muxByte;
            Busy    = 1'b1;
         end
         StDone: begin
            Busy      = 1'b1;
            FrameDone = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byteIdx <= 3'd0;
         pending <= 1'b0;
         snap    <= '0;
      end else begin
         if (takeSnap) begin
            snap    <= freshSnap;
            byteIdx <= 3'd0;
         end else if (handshake) begin
            byteIdx <= lastByte ? 3'd0 : byteIdx + 3'd1;
         end
         if (state == StDone)
            pending <= 1'b0;
         else if ((state == StSend) && ReportReq)
            pending <= 1'b1;
      end
   end

`ifdef WEBSHOOTER_TX_CHECKSUM_EN
   logic [7:0] checksum;

   // Running XOR of the bytes already accepted; it is complete by the
   // time the index reaches the checksum slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         checksum <= 8'h00;
      else if (takeSnap)
         checksum <= 8'h00;
      else if (handshake && !lastByte)
         checksum <= checksum ^ muxByte;
   end

   assign csumByte = checksum;
`else
   assign csumByte = 8'h00;
`endif

   webshooter_frame_mux uMux (
      .snapBits  (snap),
      .byteIndex (byteIdx),
      .checksum  (csumByte),
      .frameByte (muxByte)
   );

endmodule

// File: tb/tb_webshooter_status_tx.sv
// Self-checking bench for webshooter_status_tx: directed scenarios
// followed by randomized frames against a frame-level reference model.
module tb_webshooter_status_tx;

`ifdef WEBSHOOTER_TX_CHECKSUM_EN
   localparam int FRAME_LEN = 8;
`else
   localparam int FRAME_LEN = 7;
`endif

   typedef logic [7:0][7:0] frame_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       ReportReq;
   logic [3:0] TelemetryTargetSelect;
   logic [2:0] WebFunctionSelect;
   logic [7:0] XCoordinate;
   logic [7:0] YCoordinate;
   logic [7:0] ZCoordinate;
   logic [7:0] TimeCoordinate;
   logic [5:0] tracerCount;
   logic       energyEmpty;
   logic [7:0] TxData;
   logic       TxValid;
   logic       TxReady;
   logic       Busy;
   logic       FrameDone;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   webshooter_status_tx dut (
      .clk                   (clk),
      .reset                 (reset),
      .ReportReq             (ReportReq),
      .TelemetryTargetSelect (TelemetryTargetSelect),
      .WebFunctionSelect     (WebFunctionSelect),
      .XCoordinate           (XCoordinate),
      .YCoordinate           (YCoordinate),
      .ZCoordinate           (ZCoordinate),
      .TimeCoordinate        (TimeCoordinate),
      .tracerCount           (tracerCount),
      .energyEmpty           (energyEmpty),
      .TxData                (TxData),
      .TxValid               (TxValid),
      .TxReady               (TxReady),
      .Busy                  (Busy),
      .FrameDone             (FrameDone)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference frame from the current input fields.
   function automatic frame_t buildFrame();
      frame_t f;
      logic [7:0] acc;
      f[0] = 8'hA5;
      f[1] = {TelemetryTargetSelect, WebFunctionSelect, 1'b0};
      f[2] = XCoordinate;
      f[3] = YCoordinate;
      f[4] = ZCoordinate;
      f[5] = TimeCoordinate;
      f[6] = {energyEmpty, 1'b0, tracerCount};
      acc = 8'h00;
      for (int i = 0; i < 7; i++) acc ^= f[i];
      f[7] = acc;
      return f;
   endfunction

   task automatic randomizeFields();
      TelemetryTargetSelect = 4'($urandom);
      WebFunctionSelect     = 3'($urandom);
      XCoordinate           = 8'($urandom);
      YCoordinate           = 8'($urandom);
      ZCoordinate           = 8'($urandom);
      TimeCoordinate        = 8'($urandom);
      tracerCount           = 6'($urandom);
      energyEmpty           = 1'($urandom);
   endtask

   task automatic setScenarioFields();
      TelemetryTargetSelect = 4'b1011;
      WebFunctionSelect     = 3'b011;
      XCoordinate           = 8'h55;
      YCoordinate           = 8'hF0;
      ZCoordinate           = 8'hAA;
      TimeCoordinate        = 8'hCC;
      tracerCount           = 6'd17;
      energyEmpty           = 1'b0;
   endtask

   // Called at a negedge in IDLE; returns at the negedge of cycle n+1.
   task automatic requestFrame();
      ReportReq = 1'b1;
      TxReady   = 1'b1;
      @(negedge clk);
      ReportReq = 1'b0;
   endtask

   // Walks a frame byte by byte starting at the negedge where byte 0
   // should be on the bus. Stalls, extra requests and input changes
   // are injected at chosen bytes. stopIdx >= 0 returns early.
   task automatic playFrame(input frame_t f, input int stallIdx,
                            input int stallLen, input logic [7:0] reqMask,
                            input int mutateIdx, input int stopIdx);
      int  idx;
      int  stalls;
      bit  first;
      bit  stop;
      idx    = 0;
      stalls = stallLen;
      first  = 1'b1;
      stop   = 1'b0;
      while (idx < FRAME_LEN && !stop) begin
         chk($sformatf("valid[%0d]", idx), TxValid, 1);
         chk($sformatf("data[%0d]", idx), TxData, f[idx]);
         chk($sformatf("busy[%0d]", idx), Busy, 1);
         chk($sformatf("noDone[%0d]", idx), FrameDone, 0);
         if (idx == stopIdx) begin
            stop = 1'b1;
         end else begin
            if (first && idx == mutateIdx) begin
               randomizeFields();
               XCoordinate = 8'h00;
            end
            ReportReq = first && reqMask[idx];
            if (idx == stallIdx && stalls > 0) begin
               TxReady = 1'b0;
               stalls--;
               first = 1'b0;
            end else begin
               TxReady = 1'b1;
               idx++;
               first = 1'b1;
            end
            @(negedge clk);
         end
      end
      ReportReq = 1'b0;
      TxReady   = 1'b1;
   endtask

   // DONE cycle; nxt is the frame a pending request would snapshot.
   task automatic checkDone(input bit expectNext, output frame_t nxt);
      chk("doneFlag", FrameDone, 1);
      chk("doneBusy", Busy, 1);
      chk("doneValid", TxValid, 0);
      nxt = buildFrame();
      ReportReq = 1'b0;
      @(negedge clk);
      if (!expectNext) begin
         chk("idleBusy", Busy, 0);
         chk("idleValid", TxValid, 0);
         chk("idleDone", FrameDone, 0);
         chk("idleData", TxData, 8'h00);
      end
   endtask

   initial begin
      frame_t f;
      frame_t f2;
      int     sIdx;
      int     sLen;
      int     mIdx;
      logic [7:0] mask;
      bit     wantPending;

      reset     = 1'b1;
      ReportReq = 1'b0;
      TxReady   = 1'b1;
      setScenarioFields();
      repeat (3) @(negedge clk);
      chk("rstValid", TxValid, 0);
      chk("rstData", TxData, 8'h00);
      chk("rstBusy", Busy, 0);
      chk("rstDone", FrameDone, 0);
      reset = 1'b0;
      @(negedge clk);

      // Scenario 1: known frame, ready held high.
      f = {8'hC1, 8'h11, 8'hCC, 8'hAA, 8'hF0, 8'h55, 8'hB6, 8'hA5};
      requestFrame();
      playFrame(f, -1, 0, 8'h00, -1, -1);
      checkDone(1'b0, f2);

      // Scenario 2: three-cycle stall on byte 3.
      requestFrame();
      playFrame(f, 3, 3, 8'h00, -1, -1);
      checkDone(1'b0, f2);

      // Scenario 3: X cleared one cycle after acceptance.
      requestFrame();
      playFrame(f, -1, 0, 8'h00, 0, -1);
      checkDone(1'b0, f2);
      chk("xChanged", XCoordinate, 8'h00);

      // Scenario 4: three requests during a frame merge into one.
      setScenarioFields();
      requestFrame();
      playFrame(f, -1, 0, 8'b0001_0110, 5, -1);
      checkDone(1'b1, f2);
      playFrame(f2, -1, 0, 8'h00, -1, -1);
      checkDone(1'b0, f2);

      // Request coinciding with the final handshake becomes pending.
      f = buildFrame();
      requestFrame();
      mask = 8'h00;
      mask[FRAME_LEN-1] = 1'b1;
      playFrame(f, -1, 0, mask, -1, -1);
      checkDone(1'b1, f2);
      playFrame(f2, -1, 0, 8'h00, -1, -1);
      checkDone(1'b0, f2);

      // Reset on byte 4 with a pending request outstanding.
      f = buildFrame();
      requestFrame();
      playFrame(f, -1, 0, 8'b0000_0010, -1, 4);
      reset = 1'b1;
      #1;
      chk("midRstValid", TxValid, 0);
      chk("midRstBusy", Busy, 0);
      chk("midRstData", TxData, 8'h00);
      chk("midRstDone", FrameDone, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("postRstValid[%0d]", i), TxValid, 0);
         chk($sformatf("postRstDone[%0d]", i), FrameDone, 0);
         chk($sformatf("postRstBusy[%0d]", i), Busy, 0);
      end
      setScenarioFields();
      f = buildFrame();
      requestFrame();
      playFrame(f, -1, 0, 8'h00, -1, -1);
      checkDone(1'b0, f2);

      // Randomized frames with stalls, merged requests and input churn.
      for (int n = 0; n < 16; n++) begin
         randomizeFields();
         f    = buildFrame();
         sIdx = $urandom_range(FRAME_LEN - 1, 0);
         sLen = $urandom_range(3, 0);
         mask = 8'h00;
         wantPending = 1'($urandom);
         if (wantPending) mask[$urandom_range(FRAME_LEN - 1, 0)] = 1'b1;
         mIdx = ($urandom_range(1, 0) == 1) ?
                $urandom_range(FRAME_LEN - 1, 0) : -1;
         requestFrame();
         playFrame(f, sIdx, sLen, mask, mIdx, -1);
         checkDone(wantPending, f2);
         if (wantPending) begin
            playFrame(f2, -1, 0, 8'h00, -1, -1);
            checkDone(1'b0, f2);
         end
         if ($urandom_range(1, 0) == 1) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
